// File: rtl/mccpu_ctrl.sv
// mccpu_ctrl -- multi-cycle CPU control unit.
//
// Steps each instruction through IF/ID/EXE/MEM/WB and drives the shared
// datapath (PC/NPC, IR, register file, ALU, unified memory). Datapath select
// encodings match the single-cycle decoder, so alu/ext/npc/RF are reused.
//
// Parameters:
//   MEM_TIMEOUT  max MEM wait cycles before the access is abandoned (0 = never)
//   CNT_W        width of the MEM wait counter (2**CNT_W > MEM_TIMEOUT)
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   Op, Funct          IR[31:26], IR[5:0] from the latched IR
//   Zero               ALU zero flag
//   MemReady           memory done handshake, sampled only in MEM
//   PCWrite, IRWrite   PC / IR load enables
//   IorD               memory address select (0 = PC, 1 = ALUOut)
//   RegWrite           register file write enable
//   MemWrite, MemRead  memory write enable / read request
//   EXTOp              1 = sign-extend immediate
//   ALUOp              NOP 0, ADD 1, SUB 2, AND 3, OR 4, SLT 5, SLTU 6, SLL 7, NOR 8
//   NPCOp              PLUS4 00, BRANCH 01, JUMP 10
//   ALUSrcA            00 = rs, 01 = shamt, 10 = lui shift amount
//   ALUSrcB            1 = immediate
//   GPRSel             destination select (0 = rd, 1 = rt)
//   WDSel              write data select (0 = ALUOut, 1 = MDR)
//   MemErr             one-cycle pulse when a MEM access times out
//   State              current FSM state for debug
//   InstRet            retired instruction count
//
// Build option: define MCCTRL_INSTRET_EN to implement the InstRet counter;
// otherwise InstRet is tied to 0.

module mccpu_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        IorD,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        EXTOp,
    output logic [3:0]  ALUOp,
    output logic [1:0]  NPCOp,
    output logic [1:0]  ALUSrcA,
    output logic        ALUSrcB,
    output logic        GPRSel,
    output logic        WDSel,
    output logic        MemErr,
    output logic [2:0]  State,
    output logic [31:0] InstRet
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_NOR  = 4'd8
    } aluop_t;

    typedef enum logic [2:0] {
        CL_BAD,
        CL_ALU,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_J
    } iclass_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    iclass_t            dec_cls;
    logic               dec_ext;
    aluop_t             dec_alu;
    logic [1:0]         dec_srca;
    logic               dec_srcb;
    logic               dec_gpr;
    logic               dec_wd;

    // Instruction decode, shared by every state from ID through WB.
    always_comb begin
        dec_cls  = CL_BAD;
        dec_ext  = 1'b0;
        dec_alu  = ALU_NOP;
        dec_srca = 2'b00;
        dec_srcb = 1'b0;
        dec_gpr  = 1'b0;
        dec_wd   = 1'b0;
        unique case (Op)
            6'b000000: begin
                dec_cls = CL_ALU;
                unique case (Funct)
                    6'b100000, 6'b100001: dec_alu = ALU_ADD;
                    6'b100010, 6'b100011: dec_alu = ALU_SUB;
                    6'b100100:            dec_alu = ALU_AND;
                    6'b100101:            dec_alu = ALU_OR;
                    6'b100111:            dec_alu = ALU_NOR;
                    6'b101010:            dec_alu = ALU_SLT;
                    6'b101011:            dec_alu = ALU_SLTU;
                    6'b000000: begin
                        dec_alu  = ALU_SLL;
                        dec_srca = 2'b01;
                    end
                    default:              dec_cls = CL_BAD;
                endcase
            end
            6'b001000: begin // addi
                dec_cls = CL_ALU; dec_ext = 1'b1; dec_alu = ALU_ADD;
                dec_srcb = 1'b1;  dec_gpr = 1'b1;
            end
            6'b001101: begin // ori
                dec_cls = CL_ALU; dec_alu = ALU_OR;
                dec_srcb = 1'b1;  dec_gpr = 1'b1;
            end
            6'b001010: begin // slti
                dec_cls = CL_ALU; dec_ext = 1'b1; dec_alu = ALU_SLT;
                dec_srcb = 1'b1;  dec_gpr = 1'b1;
            end
            6'b001111: begin // lui: zero-extended imm on B shifted left by 16 from A
                dec_cls = CL_ALU; dec_alu = ALU_SLL; dec_srca = 2'b10;
                dec_srcb = 1'b1;  dec_gpr = 1'b1;
            end
            6'b100011: begin // lw
                dec_cls = CL_LW; dec_ext = 1'b1; dec_alu = ALU_ADD;
                dec_srcb = 1'b1; dec_gpr = 1'b1; dec_wd = 1'b1;
            end
            6'b101011: begin // sw
                dec_cls = CL_SW; dec_ext = 1'b1; dec_alu = ALU_ADD;
                dec_srcb = 1'b1;
            end
            6'b000100: begin // beq
                dec_cls = CL_BEQ; dec_ext = 1'b1; dec_alu = ALU_SUB;
            end
            6'b000010: dec_cls = CL_J;
            default:   dec_cls = CL_BAD;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and outputs. Everything is gated by rstn so the datapath
    // sees no enable while reset is held, even though the state sits in IF.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        EXTOp    = 1'b0;
        ALUOp    = ALU_NOP;
        NPCOp    = 2'b00;
        ALUSrcA  = 2'b00;
        ALUSrcB  = 1'b0;
        GPRSel   = 1'b0;
        WDSel    = 1'b0;
        MemErr   = 1'b0;

        if (rstn) begin
            if (state_q inside {S_ID, S_EXE, S_MEM, S_WB}) begin
                EXTOp   = dec_ext;
                ALUOp   = dec_alu;
                ALUSrcA = dec_srca;
                ALUSrcB = dec_srcb;
                GPRSel  = dec_gpr;
                WDSel   = dec_wd;
            end

            case (state_q)
                S_IF: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_ID;
                end
                S_ID: begin
                    if (dec_cls == CL_J) begin
                        PCWrite = 1'b1;
                        NPCOp   = 2'b10;
                        state_d = S_IF;
                    end else if (dec_cls == CL_BAD) begin
                        state_d = S_IF;
                    end else begin
                        state_d = S_EXE;
                    end
                end
                S_EXE: begin
                    unique case (dec_cls)
                        CL_BEQ: begin
                            PCWrite = Zero;
                            NPCOp   = 2'b01;
                            state_d = S_IF;
                        end
                        CL_LW, CL_SW: state_d = S_MEM;
                        CL_ALU:       state_d = S_WB;
                        default:      state_d = S_IF;
                    endcase
                end
                S_MEM: begin
                    IorD     = 1'b1;
                    MemRead  = (dec_cls == CL_LW);
                    MemWrite = (dec_cls == CL_SW);
                    // MemReady is checked before the timeout so a late
                    // completion on the final allowed cycle still succeeds.
                    if (MemReady) begin
                        state_d = (dec_cls == CL_LW) ? S_WB : S_IF;
                    end else if (MEM_TIMEOUT != 0 && cnt_q == CNT_W'(MEM_TIMEOUT)) begin
                        MemErr  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    state_d  = S_IF;
                end
                default: begin
                    EXTOp   = 1'b0;
                    ALUOp   = ALU_NOP;
                    ALUSrcA = 2'b00;
                    ALUSrcB = 1'b0;
                    GPRSel  = 1'b0;
                    WDSel   = 1'b0;
                    state_d = S_IF;
                end
            endcase
        end
    end

    assign State = state_q;

`ifdef MCCTRL_INSTRET_EN
    logic        retire;
    logic [31:0] instret_q;

    // Last cycle of each completed sequence; aborts never reach these terms.
    always_comb begin
        retire = ((state_q == S_ID)  && (dec_cls == CL_J))
              || ((state_q == S_EXE) && (dec_cls == CL_BEQ))
              || ((state_q == S_MEM) && (dec_cls == CL_SW) && MemReady)
              ||  (state_q == S_WB);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign InstRet = instret_q;
`else
    assign InstRet = '0;
`endif

endmodule

// File: tb/tb_mccpu_ctrl.sv
module tb_mccpu_ctrl;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  Op, Funct;
    logic        Zero, MemReady;
    logic        PCWrite, IRWrite, IorD, RegWrite, MemWrite, MemRead, EXTOp;
    logic [3:0]  ALUOp;
    logic [1:0]  NPCOp, ALUSrcA;
    logic        ALUSrcB, GPRSel, WDSel, MemErr;
    logic [2:0]  State;
    logic [31:0] InstRet;

    mccpu_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .IorD(IorD), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemRead(MemRead), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .GPRSel(GPRSel),
        .WDSel(WDSel), .MemErr(MemErr), .State(State), .InstRet(InstRet)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        pcw, irw, iord, rw, mwr, mrd, ext;
        logic [3:0]  aop;
        logic [1:0]  npc, srca;
        logic        srcb, gpr, wd, err;
        logic [31:0] ir;
    } out_t;

    typedef enum int {C_ALU, C_LW, C_SW, C_BEQ, C_J, C_BAD} cls_e;

    typedef struct {
        logic [31:0] instr;
        cls_e        cls;
        logic        ext;
        logic [3:0]  aop;
        logic [1:0]  srca;
        logic        srcb, gpr, wd;
    } vec_t;

    vec_t        tbl[22];
    int          errors = 0;
    int          checks = 0;
    int unsigned retired = 0;

    function automatic out_t actual();
        return '{State, PCWrite, IRWrite, IorD, RegWrite, MemWrite, MemRead,
                 EXTOp, ALUOp, NPCOp, ALUSrcA, ALUSrcB, GPRSel, WDSel,
                 MemErr, InstRet};
    endfunction

    task automatic check(input out_t e, input string nm);
        out_t a;
        a = actual();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    function automatic logic rz();
        return 1'($urandom);
    endfunction

    function automatic out_t blank(input logic [2:0] st);
        out_t o;
        o = '0;
        o.st = st;
`ifdef MCCTRL_INSTRET_EN
        o.ir = retired;
`endif
        return o;
    endfunction

    function automatic out_t dec(input out_t o, input vec_t d);
        if (d.cls != C_BAD) begin
            o.ext = d.ext; o.aop = d.aop; o.srca = d.srca;
            o.srcb = d.srcb; o.gpr = d.gpr; o.wd = d.wd;
        end
        return o;
    endfunction

    // One clock: drive inputs just after the edge, check mid-cycle.
    task automatic cyc(input out_t e, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic mr, input string nm);
        Op = op; Funct = fn; Zero = z; MemReady = mr;
        #3;
        check(e, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rstn = 1'b0;
        retired = 0;
        #1;
        check('0, "rst_assert");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            Op = 6'($urandom); Funct = 6'($urandom); Zero = rz(); MemReady = rz();
            #1;
            check('0, "rst_hold");
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Expected sequence per instruction class; waits = MEM cycles before
    // MemReady, rst_k = MEM cycle at which reset is pulled (-1 = never).
    task automatic run_instr(input int idx, input logic z, input int waits, input int rst_k);
        vec_t       d;
        out_t       e;
        logic [5:0] op, fn;
        logic       mr, tmo;
        d  = tbl[idx];
        op = d.instr[31:26];
        fn = d.instr[5:0];

        e = blank(3'd0); e.pcw = 1'b1; e.irw = 1'b1; e.mrd = 1'b1;
        cyc(e, 6'($urandom), 6'($urandom), rz(), rz(), "IF");

        e = dec(blank(3'd1), d);
        if (d.cls == C_J) begin e.pcw = 1'b1; e.npc = 2'b10; end
        cyc(e, op, fn, rz(), rz(), "ID");
        if (d.cls == C_J) begin retired++; return; end
        if (d.cls == C_BAD) return;

        e = dec(blank(3'd2), d);
        if (d.cls == C_BEQ) begin
            e.pcw = z; e.npc = 2'b01;
            cyc(e, op, fn, z, rz(), "EXE_beq");
            retired++;
            return;
        end
        cyc(e, op, fn, rz(), rz(), "EXE");

        if (d.cls == C_LW || d.cls == C_SW) begin
            for (int k = 0; k <= int'(TMO); k++) begin
                mr = (k == waits);
                if (k == rst_k) begin
                    Op = op; Funct = fn; MemReady = 1'b0;
                    reset_pulse();
                    return;
                end
                tmo = (k == int'(TMO)) && !mr;
                e = dec(blank(3'd3), d);
                e.iord = 1'b1;
                e.mrd  = (d.cls == C_LW);
                e.mwr  = (d.cls == C_SW);
                e.err  = tmo;
                cyc(e, op, fn, rz(), mr, tmo ? "MEM_timeout" : "MEM");
                if (tmo) return;
                if (mr) break;
            end
            if (d.cls == C_SW) begin retired++; return; end
        end

        e = dec(blank(3'd4), d);
        e.rw = 1'b1;
        cyc(e, op, fn, rz(), rz(), "WB");
        retired++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // instr, class, EXTOp, ALUOp, ALUSrcA, ALUSrcB, GPRSel, WDSel
        tbl[0]  = '{32'h20010005, C_ALU, 1'b1, 4'd1, 2'd0, 1'b1, 1'b1, 1'b0}; // addi
        tbl[1]  = '{32'h00221820, C_ALU, 1'b0, 4'd1, 2'd0, 1'b0, 1'b0, 1'b0}; // add
        tbl[2]  = '{32'h00221821, C_ALU, 1'b0, 4'd1, 2'd0, 1'b0, 1'b0, 1'b0}; // addu
        tbl[3]  = '{32'h00221822, C_ALU, 1'b0, 4'd2, 2'd0, 1'b0, 1'b0, 1'b0}; // sub
        tbl[4]  = '{32'h00221823, C_ALU, 1'b0, 4'd2, 2'd0, 1'b0, 1'b0, 1'b0}; // subu
        tbl[5]  = '{32'h00221824, C_ALU, 1'b0, 4'd3, 2'd0, 1'b0, 1'b0, 1'b0}; // and
        tbl[6]  = '{32'h00221825, C_ALU, 1'b0, 4'd4, 2'd0, 1'b0, 1'b0, 1'b0}; // or
        tbl[7]  = '{32'h00221827, C_ALU, 1'b0, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0}; // nor
        tbl[8]  = '{32'h0022182A, C_ALU, 1'b0, 4'd5, 2'd0, 1'b0, 1'b0, 1'b0}; // slt
        tbl[9]  = '{32'h0022182B, C_ALU, 1'b0, 4'd6, 2'd0, 1'b0, 1'b0, 1'b0}; // sltu
        tbl[10] = '{32'h00021940, C_ALU, 1'b0, 4'd7, 2'd1, 1'b0, 1'b0, 1'b0}; // sll
        tbl[11] = '{32'h34010005, C_ALU, 1'b0, 4'd4, 2'd0, 1'b1, 1'b1, 1'b0}; // ori
        tbl[12] = '{32'h28010005, C_ALU, 1'b1, 4'd5, 2'd0, 1'b1, 1'b1, 1'b0}; // slti
        tbl[13] = '{32'h3C011234, C_ALU, 1'b0, 4'd7, 2'd2, 1'b1, 1'b1, 1'b0}; // lui
        tbl[14] = '{32'h8C010004, C_LW,  1'b1, 4'd1, 2'd0, 1'b1, 1'b1, 1'b1}; // lw
        tbl[15] = '{32'hAC010004, C_SW,  1'b1, 4'd1, 2'd0, 1'b1, 1'b0, 1'b0}; // sw
        tbl[16] = '{32'h10220003, C_BEQ, 1'b1, 4'd2, 2'd0, 1'b0, 1'b0, 1'b0}; // beq
        tbl[17] = '{32'h08000010, C_J,   1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0}; // j
        tbl[18] = '{32'h0000003F, C_BAD, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0}; // bad funct
        tbl[19] = '{32'h24010005, C_BAD, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0}; // addiu
        tbl[20] = '{32'hFC000000, C_BAD, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0}; // op 3F
        tbl[21] = '{32'h00200008, C_BAD, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0}; // jr

        Op = '0; Funct = '0; Zero = 1'b0; MemReady = 1'b0;
        rstn = 1'b1;
        #1;
        reset_pulse();

        // Directed corner sequences.
        run_instr(0, 1'b0, 0, -1);    // addi
        run_instr(14, 1'b0, 3, -1);   // lw, ready after 3 waits
        run_instr(16, 1'b1, 0, -1);   // beq taken
        run_instr(16, 1'b0, 0, -1);   // beq not taken
        run_instr(17, 1'b0, 0, -1);   // j
        run_instr(15, 1'b0, 100, -1); // sw timeout
        run_instr(15, 1'b0, 16, -1);  // ready on the final allowed cycle wins
        run_instr(14, 1'b0, 100, -1); // lw timeout
        run_instr(15, 1'b0, 5, 2);    // reset mid-MEM
        run_instr(1, 1'b0, 0, -1);    // fresh instruction after reset

        // Whole decode table.
        for (int i = 0; i < 22; i++) begin
            run_instr(i, rz(), int'($urandom_range(0, 4)), -1);
        end

        // Random instruction stream.
        for (int n = 0; n < 150; n++) begin
            int r;
            int w;
            r = int'($urandom_range(0, 9));
            w = (r < 7) ? r : ((r == 7) ? int'(TMO) : int'(TMO) + 1);
            run_instr(int'($urandom_range(0, 21)), rz(), w, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
